decode_stage: RTL and testbench



---
 rtl/decode_stage_pkg.sv | 64 ++++++
 rtl/decode_stage_if.sv | 23 ++
 rtl/decode_comb.sv | 118 +++++++++++
 rtl/decode_stage.sv | 82 ++++++++
 tb/tb_decode_stage.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcodes, control-word struct and immediate helpers
// used by the ID stage and its combinational decoder.
package decode_stage_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0]  F7_BASE  = 7'b0000000;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [11:0] ECALL_I  = 12'h000;
  localparam logic [11:0] EBREAK_I = 12'h001;

  typedef logic [4:0] reg_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  typedef enum logic {SGN_SIGNED, SGN_UNSIGNED} sign_t;
  typedef enum logic [2:0] {
    BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111
  } B_F3_t;

  typedef enum logic [3:0] {
    ALU, ALU_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM
  } op_class_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef struct packed {
    op_class_t   opclass;
    alu_op_t     alu_op;
    reg_t        rs1;
    reg_t        rs2;
    reg_t        rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        we;
    size_t       mem_size;
    sign_t       mem_sign;
    B_F3_t       br_f3;
    logic        is_ecall;
    logic        is_ebreak;
    logic        illegal;
  } dec_ctrl_t;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF->ID and ID->EX handshake bundle; slave is the decode stage, master the environment.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic              if_valid_i;
  logic              if_ready_o;
  logic [31:0]       if_instr_i;
  logic [XLEN_W-1:0] if_pc_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [XLEN_W-1:0] id_pc_o;
  dec_ctrl_t         id_ctrl_o;

  modport slave (
    input  if_valid_i, if_instr_i, if_pc_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, id_ctrl_o
  );

  modport master (
    output if_valid_i, if_instr_i, if_pc_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_ctrl_o
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: instruction word -> control word.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter bit ZERO_RD_ON_NOWRITE = 1'b1
) (
  input  logic [31:0] instr_i,
  output dec_ctrl_t   ctrl_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_u, imm_sh;
  logic        writes, illegal;
  alu_op_t     base_op;
  dec_ctrl_t   c;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u  = {instr_i[31:12], 12'h000};
  assign imm_sh = {27'b0, instr_i[24:20]};

  // funct3 selects the same operation for register and immediate ALU forms
  always_comb begin
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    c       = '0;
    writes  = 1'b0;
    illegal = 1'b0;
    c.rs1   = instr_i[19:15];
    c.rs2   = instr_i[24:20];
    c.rd    = instr_i[11:7];
    case (opcode)
      OP_LUI: begin
        c.opclass = LUI;  c.alu_op = ALU_PASS_B; c.imm = imm_u; c.use_imm = 1'b1; writes = 1'b1;
      end
      OP_AUIPC: begin
        c.opclass = AUIPC; c.imm = imm_u; c.use_imm = 1'b1; writes = 1'b1;
      end
      OP_JAL: begin
        c.opclass = JAL; c.imm = imm_j(instr_i); c.use_imm = 1'b1; writes = 1'b1;
      end
      OP_JALR: begin
        c.opclass = JALR; c.imm = imm_i; c.use_imm = 1'b1; writes = 1'b1;
        illegal   = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        c.opclass = BRANCH; c.alu_op = ALU_SUB; c.imm = imm_b(instr_i); c.br_f3 = B_F3_t'(f3);
        illegal   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        c.opclass  = LOAD; c.imm = imm_i; c.use_imm = 1'b1; writes = 1'b1;
        c.mem_size = size_t'(f3[1:0]);
        c.mem_sign = sign_t'(f3[2]);
        illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        c.opclass  = STORE; c.imm = imm_s; c.use_imm = 1'b1;
        c.mem_size = size_t'(f3[1:0]);
        illegal    = (f3 >= 3'b011);
      end
      OP_IMM: begin
        c.opclass = ALU_IMM; c.alu_op = base_op; c.imm = imm_i; c.use_imm = 1'b1; writes = 1'b1;
        if (f3 == 3'b001) begin
          c.imm   = imm_sh;
          illegal = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          c.imm = imm_sh;
          if (f7 == F7_ALT) c.alu_op = ALU_SRA;
          else              illegal  = (f7 != F7_BASE);
        end
      end
      OP_REG: begin
        c.opclass = ALU; c.alu_op = base_op; writes = 1'b1;
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      c.alu_op = ALU_SUB;
          else if (f3 == 3'b101) c.alu_op = ALU_SRA;
          else                   illegal  = 1'b1;
        end else begin
          illegal = (f7 != F7_BASE);
        end
      end
      OP_SYSTEM: begin
        c.opclass = SYSTEM; c.imm = imm_i;
        // only the exact ECALL/EBREAK encodings are accepted
        if (instr_i[19:15] == 5'd0 && instr_i[11:7] == 5'd0 && f3 == 3'b000 &&
            instr_i[31:20] == ECALL_I)
          c.is_ecall = 1'b1;
        else if (instr_i[19:15] == 5'd0 && instr_i[11:7] == 5'd0 && f3 == 3'b000 &&
                 instr_i[31:20] == EBREAK_I)
          c.is_ebreak = 1'b1;
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    c.illegal = illegal;
    c.we      = writes && !illegal && (c.rd != 5'd0);
    if (ZERO_RD_ON_NOWRITE && !(writes && !illegal)) c.rd = '0;
    ctrl_o = c;
  end

endmodule

// File: rtl/decode_stage.sv
// ID pipeline stage: decodes on accept into a two-entry skid buffer (out + skid)
// so that both if_ready_o and id_valid_o come straight from flops.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN               = XLEN_W,
  parameter bit ZERO_RD_ON_NOWRITE = 1'b1
) (
  input logic          clk,
  input logic          rst,
  input logic          flush_i,
  decode_stage_if.slave io
);

  dec_ctrl_t       dec_ctrl;
  logic            accept, drain;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  dec_ctrl_t       out_ctrl_q, out_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;

  decode_comb #(.ZERO_RD_ON_NOWRITE(ZERO_RD_ON_NOWRITE)) u_decode (
    .instr_i (io.if_instr_i),
    .ctrl_o  (dec_ctrl)
  );

  assign accept = io.if_valid_i && !skid_valid_q;
  assign drain  = out_valid_q && io.id_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // full: input is blocked, a drain promotes the skid entry
      if (drain) begin
        out_ctrl_d   = skid_ctrl_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept && (!out_valid_q || drain)) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = dec_ctrl;
      out_pc_d    = io.if_pc_i;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = dec_ctrl;
      skid_pc_d    = io.if_pc_i;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_ctrl_q   <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ctrl_q   <= out_ctrl_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign io.if_ready_o = !skid_valid_q;
  assign io.id_valid_o = out_valid_q;
  assign io.id_pc_o    = out_pc_q;
  assign io.id_ctrl_o  = out_ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode cases, backpressure/flush/reset scenarios
// and random traffic checked against a queue-based reference of the stage.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] obs_pc[$];
  int          obs_cyc[$];

  decode_stage_if bus();

  decode_stage dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .io      (bus)
  );

  always #5 clk = ~clk;

  function automatic alu_op_t ref_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;  3'd1: return ALU_SLL;  3'd2: return ALU_SLT;  3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;  3'd5: return ALU_SRL;  3'd6: return ALU_OR;   default: return ALU_AND;
    endcase
  endfunction

  // Reference decoder derived from the RV32I base encoding rules.
  function automatic dec_ctrl_t ref_decode(input logic [31:0] ins);
    dec_ctrl_t   c;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii;
    bit          wr, ok;
    c  = '0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = $signed(ins) >>> 20;
    wr = 1'b0;
    ok = 1'b1;
    c.rs1 = ins[19:15];
    c.rs2 = ins[24:20];
    case (ins[6:0])
      7'h37: begin c.opclass = LUI; c.alu_op = ALU_PASS_B; c.imm = ins & 32'hFFFFF000; c.use_imm = 1'b1; wr = 1'b1; end
      7'h17: begin c.opclass = AUIPC; c.imm = ins & 32'hFFFFF000; c.use_imm = 1'b1; wr = 1'b1; end
      7'h6F: begin
        c.opclass = JAL; c.use_imm = 1'b1; wr = 1'b1;
        c.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: begin c.opclass = JALR; c.imm = ii; c.use_imm = 1'b1; wr = 1'b1; ok = (f3 == 3'd0); end
      7'h63: begin
        c.opclass = BRANCH; c.alu_op = ALU_SUB; c.br_f3 = B_F3_t'(f3);
        c.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ok = !(f3 inside {3'd2, 3'd3});
      end
      7'h03: begin
        c.opclass = LOAD; c.imm = ii; c.use_imm = 1'b1; wr = 1'b1;
        c.mem_size = size_t'(f3[1:0]); c.mem_sign = f3[2] ? SGN_UNSIGNED : SGN_SIGNED;
        ok = !(f3 inside {3'd3, 3'd6, 3'd7});
      end
      7'h23: begin
        c.opclass = STORE; c.imm = {ii[31:5], ins[11:7]}; c.use_imm = 1'b1;
        c.mem_size = size_t'(f3[1:0]); ok = (f3 < 3'd3);
      end
      7'h13: begin
        c.opclass = ALU_IMM; c.use_imm = 1'b1; wr = 1'b1; c.imm = ii; c.alu_op = ref_alu(f3);
        if (f3 == 3'd1 || f3 == 3'd5) c.imm = {27'd0, ins[24:20]};
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) c.alu_op = ALU_SRA;
        end
      end
      7'h33: begin
        c.opclass = ALU; wr = 1'b1; c.alu_op = ref_alu(f3);
        if (f7 == 7'h20 && f3 == 3'd0)      c.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) c.alu_op = ALU_SRA;
        else if (f7 != 7'h00)               ok = 1'b0;
      end
      7'h73: begin
        c.opclass = SYSTEM; c.imm = ii;
        c.is_ecall  = (ins == 32'h00000073);
        c.is_ebreak = (ins == 32'h00100073);
        ok = c.is_ecall || c.is_ebreak;
      end
      default: ok = 1'b0;
    endcase
    c.illegal = !ok;
    c.we      = wr && ok && (ins[11:7] != 5'd0);
    c.rd      = (wr && ok) ? ins[11:7] : 5'd0;
    return c;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] w;
    int          sel;
    w   = $urandom();
    sel = int'($urandom_range(0, 11));
    if (sel == 10) return w;
    if (sel == 11) return ($urandom_range(0, 1) == 1) ? 32'h00000073 : 32'h00100073;
    w[6:0] = ops[sel];
    case ($urandom_range(0, 2))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: compare DUT against the model, apply inputs, advance the model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    dec_ctrl_t exp;
    bit        drn, acc;
    checks++;
    if (bus.id_valid_o !== (mq.size() > 0))
      $display("FAIL id_valid cyc=%0d got=%b want=%b", cyc, bus.id_valid_o, mq.size() > 0);
    if (bus.id_valid_o !== (mq.size() > 0)) errors++;
    checks++;
    if (bus.if_ready_o !== (mq.size() < 2)) begin
      errors++;
      $display("FAIL if_ready cyc=%0d got=%b want=%b", cyc, bus.if_ready_o, mq.size() < 2);
    end
    if (mq.size() > 0) begin
      exp = ref_decode(mq[0].instr);
      checks++;
      if (bus.id_pc_o !== mq[0].pc) begin
        errors++;
        $display("FAIL id_pc cyc=%0d got=%h want=%h", cyc, bus.id_pc_o, mq[0].pc);
      end
      checks++;
      if (exp.illegal ? (bus.id_ctrl_o.illegal !== 1'b1 || bus.id_ctrl_o.we !== 1'b0)
                      : (bus.id_ctrl_o !== exp)) begin
        errors++;
        $display("FAIL id_ctrl cyc=%0d instr=%h got=%h want=%h", cyc, mq[0].instr, bus.id_ctrl_o, exp);
      end
    end
    if (bus.id_valid_o === 1'b1 && rdy && !fl) begin
      obs_pc.push_back(bus.id_pc_o);
      obs_cyc.push_back(cyc);
      $display("xfer cyc=%0d pc=%h opclass=%0d illegal=%b", cyc, bus.id_pc_o,
               bus.id_ctrl_o.opclass, bus.id_ctrl_o.illegal);
    end
    bus.if_valid_i = v;
    bus.if_instr_i = ins;
    bus.if_pc_i    = pc;
    bus.id_ready_i = rdy;
    flush          = fl;
    if (fl) begin
      mq.delete();
    end else begin
      drn = (mq.size() > 0) && rdy;
      acc = v && (mq.size() < 2);
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc, instr: ins});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.if_valid_i = 1'b0; bus.if_instr_i = '0; bus.if_pc_i = '0; bus.id_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    checks++; if (bus.id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.id_valid_o); end
    checks++; if (bus.if_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.if_ready_o); end
    checks++; if (bus.id_pc_o !== '0) begin errors++; $display("FAIL reset_pc got=%h want=0", bus.id_pc_o); end
    checks++; if (bus.id_ctrl_o !== '0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", bus.id_ctrl_o); end
  endtask

  typedef struct {
    logic [31:0] ins;
    op_class_t   cls;
    alu_op_t     alu;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        we;
    logic        ill;
    logic        ebr;
  } dir_t;

  task automatic test_decode();
    dir_t tab[8];
    tab[0] = '{32'hFFF00513, ALU_IMM, ALU_ADD,    5'd10, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tab[1] = '{32'h00B12423, STORE,   ALU_ADD,    5'd0,  32'h00000008, 1'b0, 1'b0, 1'b0};
    tab[2] = '{32'hFE000EE3, BRANCH,  ALU_SUB,    5'd0,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    tab[3] = '{32'h12345537, LUI,     ALU_PASS_B, 5'd10, 32'h12345000, 1'b1, 1'b0, 1'b0};
    tab[4] = '{32'h407302B3, ALU,     ALU_SUB,    5'd5,  32'h00000000, 1'b1, 1'b0, 1'b0};
    tab[5] = '{32'h00000000, ALU,     ALU_ADD,    5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0};
    tab[6] = '{32'h4200D293, ALU,     ALU_ADD,    5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0};
    tab[7] = '{32'h00100073, SYSTEM,  ALU_ADD,    5'd0,  32'h00000001, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, tab[k].ins, 32'h1000 + 32'(k) * 4, 1'b1, 1'b0);
      checks++;
      if (bus.id_valid_o !== 1'b1) begin errors++; $display("FAIL dir_latency k=%0d got=%b want=1", k, bus.id_valid_o); end
      checks++;
      if (bus.id_ctrl_o.illegal !== tab[k].ill || bus.id_ctrl_o.we !== tab[k].we) begin
        errors++;
        $display("FAIL dir_ill_we k=%0d got=%b%b want=%b%b", k, bus.id_ctrl_o.illegal, bus.id_ctrl_o.we, tab[k].ill, tab[k].we);
      end
      if (!tab[k].ill) begin
        checks++;
        if (bus.id_ctrl_o.opclass !== tab[k].cls || bus.id_ctrl_o.alu_op !== tab[k].alu ||
            bus.id_ctrl_o.rd !== tab[k].rd || bus.id_ctrl_o.imm !== tab[k].imm ||
            bus.id_ctrl_o.is_ebreak !== tab[k].ebr) begin
          errors++;
          $display("FAIL dir_fields k=%0d got=%0d/%0d/%0d/%h/%b want=%0d/%0d/%0d/%h/%b", k,
                   bus.id_ctrl_o.opclass, bus.id_ctrl_o.alu_op, bus.id_ctrl_o.rd, bus.id_ctrl_o.imm,
                   bus.id_ctrl_o.is_ebreak, tab[k].cls, tab[k].alu, tab[k].rd, tab[k].imm, tab[k].ebr);
        end
      end
      if (k == 0) begin
        checks++;
        if (bus.id_ctrl_o.rs1 !== 5'd0) begin errors++; $display("FAIL addi_rs1 got=%0d want=0", bus.id_ctrl_o.rs1); end
      end
      if (k == 1) begin
        checks++;
        if (bus.id_ctrl_o.rs1 !== 5'd2 || bus.id_ctrl_o.rs2 !== 5'd11 || bus.id_ctrl_o.mem_size !== SZ_WORD) begin
          errors++;
          $display("FAIL sw_fields got=%0d/%0d/%0d want=2/11/%0d", bus.id_ctrl_o.rs1, bus.id_ctrl_o.rs2,
                   bus.id_ctrl_o.mem_size, SZ_WORD);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.id_ctrl_o.br_f3 !== BEQ) begin errors++; $display("FAIL beq_f3 got=%0d want=0", bus.id_ctrl_o.br_f3); end
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    obs_pc.delete();
    obs_cyc.delete();
    cycle(1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h104, 1'b0, 1'b0);
    checks++;
    if (bus.if_ready_o !== 1'b0 || bus.id_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL b2b_full got=%b/%h want=0/00000100", bus.if_ready_o, bus.id_pc_o);
    end
    cycle(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs_pc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=3", obs_pc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_pc[k] !== 32'h100 + 32'(k) * 4) begin
          errors++;
          $display("FAIL b2b_order k=%0d got=%h want=%h", k, obs_pc[k], 32'h100 + 32'(k) * 4);
        end
      end
      checks++;
      if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
        errors++;
        $display("FAIL b2b_gap got=%0d,%0d,%0d want=consecutive", obs_cyc[0], obs_cyc[1], obs_cyc[2]);
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b1);
    checks++;
    if (bus.id_valid_o !== 1'b0 || bus.if_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got=%b/%b want=0/1", bus.id_valid_o, bus.if_ready_o);
    end
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    bus.if_valid_i = 1'b1;
    bus.if_instr_i = 32'h00300193;
    bus.if_pc_i    = 32'h308;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.if_valid_i = 1'b0;
    mq.delete();
    checks++;
    if (bus.id_valid_o !== 1'b0 || bus.if_ready_o !== 1'b1 || bus.id_pc_o !== '0 || bus.id_ctrl_o !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%b/%h/%h want=0/1/0/0", bus.id_valid_o, bus.if_ready_o, bus.id_pc_o, bus.id_ctrl_o);
    end
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h8000_0000;
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 9) < 7, gen_instr(), pc, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
      pc += 4;
    end
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
